// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory-access stage: word width, RV32I load/store
// funct3 codes, FSM state encodings, bus command payload and misalignment check.
package mem_lsu_pkg;

   localparam int unsigned WORD_WIDTH = 32;
   localparam int unsigned BE_W       = 4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Request payload presented on the data bus.
   typedef struct packed {
      logic                  we;
      logic [WORD_WIDTH-1:0] addr;
      logic [BE_W-1:0]       be;
      logic [WORD_WIDTH-1:0] wdata;
   } bus_cmd_t;

   // Word access needs addr[1:0]==0, halfword access needs addr[0]==0.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      return ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) ||
             ((funct3[1:0] == 2'b01) && addr_lo[0]);
   endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load data extraction: selects byte/half/word from the captured read word and
// sign- or zero-extends it.
//   rdata   : captured bus read word
//   addr    : low two bits of the effective address
//   funct3  : RV32I load funct3 (bit 2 = unsigned)
//   rd_data : aligned, extended load result
module mem_load_align
   import mem_lsu_pkg::*;
#(
   parameter int unsigned DATA_W = WORD_WIDTH
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] rd_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sext;

   // Lane select and extension.
   always_comb begin
      byte_sel = rdata[{addr, 3'b000} +: 8];
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      sext     = ~funct3[2];
      rd_data  = rdata;
      case (funct3[1:0])
         2'b00:   rd_data = {{(DATA_W-8){byte_sel[7] & sext}}, byte_sel};
         2'b01:   rd_data = {{(DATA_W-16){half_sel[15] & sext}}, half_sel};
         default: rd_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage. Non-memory instructions pass straight through
// to writeback; loads/stores issue one req/gnt/rvalid bus transaction and stall
// the pipeline until the response returns.
//   mem_*_i      : instruction in MEM (pc, valid, load/store, funct3, addr, data, rd)
//   mem_flush_i  : pipeline flush
//   bus_*        : single-outstanding data bus (req/we/addr/be/wdata, gnt/rvalid/rdata)
//   mem_stall_req_o, mem_misalign_o : to pipeline control
//   mem_wb_*_o   : MEM/WB payload
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = WORD_WIDTH,
   parameter int unsigned DATA_W = WORD_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] mem_pc_i,
   input  logic              mem_valid_i,
   input  logic              mem_load_i,
   input  logic              mem_store_i,
   input  logic [2:0]        mem_funct3_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_store_data_i,
   input  logic [4:0]        mem_rd_addr_i,
   input  logic              mem_rd_we_i,
   input  logic              mem_flush_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   output logic              mem_stall_req_o,
   output logic              mem_misalign_o,
   output logic [ADDR_W-1:0] mem_wb_pc_o,
   output logic              mem_wb_valid_o,
   output logic [4:0]        mem_wb_rd_addr_o,
   output logic              mem_wb_rd_we_o,
   output logic [DATA_W-1:0] mem_wb_rd_data_o
);

   logic [1:0]        state_q, state_d;
   logic              flush_q, flush_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] load_data;
   logic              is_mem, mis, mem_op;
   bus_cmd_t          cmd;

   assign is_mem = mem_valid_i & (mem_load_i | mem_store_i);
   assign mis    = is_misaligned(mem_funct3_i, mem_addr_i[1:0]);
   assign mem_op = is_mem & ~mis;

   // Store byte-lane steering; loads always read the whole word.
   always_comb begin
      cmd.we    = mem_store_i;
      cmd.addr  = {mem_addr_i[ADDR_W-1:2], 2'b00};
      cmd.be    = 4'b1111;
      cmd.wdata = mem_store_data_i;
      if (mem_store_i) begin
         case (mem_funct3_i[1:0])
            2'b00: begin
               cmd.be    = 4'b0001 << mem_addr_i[1:0];
               cmd.wdata = {4{mem_store_data_i[7:0]}};
            end
            2'b01: begin
               cmd.be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
               cmd.wdata = {2{mem_store_data_i[15:0]}};
            end
            default: ;
         endcase
      end
   end

   mem_load_align #(.DATA_W(DATA_W)) u_load_align (
      .rdata   (rdata_q),
      .addr    (mem_addr_i[1:0]),
      .funct3  (mem_funct3_i),
      .rd_data (load_data)
   );

   // State, sticky flush and captured read data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         flush_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         if ((state_q == ST_WAIT) && bus_rvalid_i) rdata_q <= bus_rdata_i;
      end
   end

   // Next state and outputs; everything forced low while in reset.
   always_comb begin
      state_d          = state_q;
      flush_d          = flush_q;
      bus_req_o        = 1'b0;
      bus_we_o         = cmd.we;
      bus_addr_o       = cmd.addr;
      bus_be_o         = cmd.be;
      bus_wdata_o      = cmd.wdata;
      mem_stall_req_o  = 1'b0;
      mem_misalign_o   = 1'b0;
      mem_wb_pc_o      = mem_pc_i;
      mem_wb_valid_o   = 1'b0;
      mem_wb_rd_addr_o = mem_rd_addr_i;
      mem_wb_rd_we_o   = 1'b0;
      mem_wb_rd_data_o = DATA_W'(mem_addr_i);

      case (state_q)
         ST_IDLE: begin
            flush_d = 1'b0;
            if (!mem_flush_i) begin
               if (mem_op) begin
                  // Request held with stable payload until granted.
                  bus_req_o       = 1'b1;
                  mem_stall_req_o = 1'b1;
                  if (bus_gnt_i) state_d = ST_WAIT;
               end else begin
                  // Pass-through, or a misaligned access retired without a write.
                  mem_wb_valid_o = mem_valid_i;
                  mem_wb_rd_we_o = mem_valid_i & mem_rd_we_i & ~is_mem;
                  mem_misalign_o = is_mem;
               end
            end
         end
         ST_WAIT: begin
            // A flush here waits for the outstanding response, then drops it.
            mem_stall_req_o = 1'b1;
            if (mem_flush_i) flush_d = 1'b1;
            if (bus_rvalid_i) begin
               flush_d = 1'b0;
               state_d = (mem_flush_i || flush_q) ? ST_IDLE : ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (!mem_flush_i) begin
               mem_wb_valid_o = 1'b1;
               mem_wb_rd_we_o = mem_load_i & mem_rd_we_i;
               if (mem_load_i) mem_wb_rd_data_o = load_data;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rst_n) begin
         bus_req_o        = 1'b0;
         bus_we_o         = 1'b0;
         bus_addr_o       = '0;
         bus_be_o         = '0;
         bus_wdata_o      = '0;
         mem_stall_req_o  = 1'b0;
         mem_misalign_o   = 1'b0;
         mem_wb_pc_o      = '0;
         mem_wb_valid_o   = 1'b0;
         mem_wb_rd_addr_o = '0;
         mem_wb_rd_we_o   = 1'b0;
         mem_wb_rd_data_o = '0;
      end
   end

endmodule
